// File: rtl/two_hot_run_monitor_pkg.sv
// Shared definitions for two_hot_run_monitor.
//   state_t     : FSM encoding; code 2'd3 is unused and recovers to IDLE
//   RUN_CNT_W   : width of the run_cnt output
package two_hot_run_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int RUN_CNT_W = 8;

endpackage

// File: rtl/two_hot_run_monitor_sat_counter.sv
// Width-parameterised saturating up-counter.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : increment request; ignored once at_max
//   count    : current value
//   at_max   : count is all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);

    assign at_max = &count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !at_max)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/two_hot_run_monitor.sv
// Qualifies the exactly-two-high indication: a run of RUN_LEN consecutive
// enabled high samples produces one det pulse and bumps a saturating event
// counter. A new event needs at least one enabled low sample in between.
//   clk, rst : clock, async active-high reset
//   en       : sample enable; disabled edges freeze all state
//   o_in     : upstream detector output
//   clr      : synchronous clear of FSM, counters and sat (highest priority)
//   det      : one-cycle event pulse (registered)
//   run_cnt  : consecutive-high count, saturates at RUN_LEN
//   evt_cnt  : saturating event count
//   sat      : sticky, set on the edge evt_cnt becomes all-ones
module two_hot_run_monitor
    import two_hot_run_monitor_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 o_in,
    input  logic                 clr,
    output logic                 det,
    output logic [RUN_CNT_W-1:0] run_cnt,
    output logic [CNT_W-1:0]     evt_cnt,
    output logic                 sat
);

    localparam logic [RUN_CNT_W-1:0] RUN_LEN_C = RUN_CNT_W'(RUN_LEN);
    // evt_cnt value one below all-ones: the increment from here saturates
    localparam logic [CNT_W-1:0]     CNT_PEN   = ~CNT_W'(1);

    state_t               state;
    logic [RUN_CNT_W-1:0] run_inc;
    logic                 sample_hi;
    logic                 fire;
    logic                 evt_at_max;

    assign run_inc   = run_cnt + 1'b1;
    assign sample_hi = !clr && en && o_in;

    // Event fires on the sample that completes the run; drives both the
    // registered det pulse and the counter increment on the same edge.
    always_comb begin
        fire = 1'b0;
        if (sample_hi) begin
            if (state == IDLE && RUN_LEN == 1)
                fire = 1'b1;
            else if (state == COUNT && run_inc == RUN_LEN_C)
                fire = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            run_cnt <= '0;
            det     <= 1'b0;
        end else begin
            det <= fire;
            if (clr) begin
                state   <= IDLE;
                run_cnt <= '0;
            end else if (en) begin
                case (state)
                    IDLE: begin
                        if (o_in) begin
                            state   <= (RUN_LEN == 1) ? LATCH : COUNT;
                            run_cnt <= RUN_CNT_W'(1);
                        end
                    end
                    COUNT: begin
                        if (o_in) begin
                            run_cnt <= run_inc;
                            if (run_inc == RUN_LEN_C)
                                state <= LATCH;
                        end else begin
                            state   <= IDLE;
                            run_cnt <= '0;
                        end
                    end
                    LATCH: begin
                        if (!o_in) begin
                            state   <= IDLE;
                            run_cnt <= '0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        run_cnt <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_evt_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .inc    (fire),
        .count  (evt_cnt),
        .at_max (evt_at_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat <= 1'b0;
        else if (clr)
            sat <= 1'b0;
        else if (fire && (evt_cnt == CNT_PEN || evt_at_max))
            sat <= 1'b1;
    end

endmodule

// File: tb/tb_two_hot_run_monitor.sv
module tb_two_hot_run_monitor;

    logic clk, rst, en, o_in, clr;

    // u0: defaults, u1: 2-bit event counter, u2: RUN_LEN=1
    logic       d0, d1, d2;
    logic [7:0] r0, r1, r2;
    logic [7:0] e0, e2;
    logic [1:0] e1;
    logic       s0, s1, s2;

    two_hot_run_monitor #(.RUN_LEN(4), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .en(en), .o_in(o_in), .clr(clr),
        .det(d0), .run_cnt(r0), .evt_cnt(e0), .sat(s0));
    two_hot_run_monitor #(.RUN_LEN(4), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .en(en), .o_in(o_in), .clr(clr),
        .det(d1), .run_cnt(r1), .evt_cnt(e1), .sat(s1));
    two_hot_run_monitor #(.RUN_LEN(1), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .en(en), .o_in(o_in), .clr(clr),
        .det(d2), .run_cnt(r2), .evt_cnt(e2), .sat(s2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       en, o_in, clr;
        logic       det;
        logic [7:0] run_cnt;
        logic [7:0] evt_cnt;
        logic       sat;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic e, input logic o, input logic c,
                       input logic d, input int r, input int ev, input logic s);
        vec_t v;
        v.en = e; v.o_in = o; v.clr = c;
        v.det = d; v.run_cnt = 8'(r); v.evt_cnt = 8'(ev); v.sat = s;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling
    // edge, after the intervening rising edge has taken effect.
    task automatic drive(input logic e, input logic o, input logic c);
        en = e; o_in = o; clr = c;
        @(negedge clk);
    endtask

    int exp_evt[5] = '{1, 2, 3, 3, 3};
    int exp_sat[5] = '{0, 0, 1, 1, 1};

    initial begin
        rst = 1'b1; en = 1'b0; o_in = 1'b0; clr = 1'b0;
        #1;
        chk("reset det u0", d0, 0);
        chk("reset run_cnt u0", r0, 0);
        chk("reset evt_cnt u0", e0, 0);
        chk("reset sat u0", s0, 0);
        chk("reset evt_cnt u1", e1, 0);
        chk("reset det u2", d2, 0);
        @(negedge clk);
        rst = 1'b0;

        // basic run of 6 highs
        add(1,1,0, 0,1,0,0); add(1,1,0, 0,2,0,0); add(1,1,0, 0,3,0,0);
        add(1,1,0, 1,4,1,0); add(1,1,0, 0,4,1,0); add(1,1,0, 0,4,1,0);
        add(1,0,0, 0,0,1,0);
        add(0,1,0, 0,0,1,0);            // disabled high from IDLE: nothing
        add(1,1,1, 0,0,0,0);            // clr discards the sample
        // 1,1,1,0,1,1,1,1
        add(1,1,0, 0,1,0,0); add(1,1,0, 0,2,0,0); add(1,1,0, 0,3,0,0);
        add(1,0,0, 0,0,0,0);
        add(1,1,0, 0,1,0,0); add(1,1,0, 0,2,0,0); add(1,1,0, 0,3,0,0);
        add(1,1,0, 1,4,1,0); add(1,0,0, 0,0,1,0);
        // o_in held, en toggling
        add(1,1,0, 0,1,1,0); add(0,1,0, 0,1,1,0); add(1,1,0, 0,2,1,0);
        add(0,1,0, 0,2,1,0); add(1,1,0, 0,3,1,0); add(0,1,0, 0,3,1,0);
        add(1,1,0, 1,4,2,0); add(0,1,0, 0,4,2,0); add(1,1,0, 0,4,2,0);
        add(1,0,0, 0,0,2,0);
        // clr on the 4th high
        add(1,1,0, 0,1,2,0); add(1,1,0, 0,2,2,0); add(1,1,0, 0,3,2,0);
        add(1,1,1, 0,0,0,0);
        add(1,1,0, 0,1,0,0); add(1,1,0, 0,2,0,0); add(1,1,0, 0,3,0,0);
        add(1,1,0, 1,4,1,0); add(1,0,0, 0,0,1,0);

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].o_in, tbl[i].clr);
            chk($sformatf("tbl[%0d] det", i),     d0, tbl[i].det);
            chk($sformatf("tbl[%0d] run_cnt", i), r0, tbl[i].run_cnt);
            chk($sformatf("tbl[%0d] evt_cnt", i), e0, tbl[i].evt_cnt);
            chk($sformatf("tbl[%0d] sat", i),     s0, tbl[i].sat);
        end

        // 2-bit counter saturation over 5 runs
        drive(1, 0, 1);
        chk("u1 clr evt_cnt", e1, 0);
        chk("u1 clr sat", s1, 0);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 3; j++) drive(1, 1, 0);
            chk($sformatf("u1 run%0d pre det", k), d1, 0);
            drive(1, 1, 0);
            chk($sformatf("u1 run%0d det", k), d1, 1);
            chk($sformatf("u1 run%0d evt_cnt", k), e1, exp_evt[k]);
            chk($sformatf("u1 run%0d sat", k), s1, exp_sat[k]);
            drive(1, 0, 0);
            chk($sformatf("u1 run%0d det off", k), d1, 0);
        end
        drive(1, 0, 1);
        chk("u1 clr2 evt_cnt", e1, 0);
        chk("u1 clr2 sat", s1, 0);

        // async reset mid-COUNT
        drive(1, 1, 0);
        drive(1, 1, 0);
        chk("pre-rst run_cnt", r0, 2);
        #2 rst = 1'b1;
        #1;
        chk("async rst run_cnt", r0, 0);
        chk("async rst det", d0, 0);
        chk("async rst evt_cnt", e0, 0);
        chk("async rst sat", s0, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post-rst run_cnt", r0, 1);
        chk("post-rst det u2", d2, 1);

        // RUN_LEN=1: each isolated high fires; held high fires once
        drive(1, 0, 0);
        chk("u2 low det", d2, 0);
        chk("u2 low run_cnt", r2, 0);
        drive(1, 1, 0);
        chk("u2 hi det", d2, 1);
        chk("u2 hi run_cnt", r2, 1);
        drive(1, 1, 0);
        chk("u2 held det", d2, 0);
        chk("u2 held run_cnt", r2, 1);
        drive(1, 0, 0);
        drive(1, 1, 0);
        chk("u2 rehi det", d2, 1);
        chk("u2 evt_cnt", e2, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/two_hot_run_monitor.md
# two_hot_run_monitor

Sequential monitor that sits directly downstream of the three-input exactly-two-high detector. It consumes the detector's single-bit output and qualifies it. When the input stays high for RUN_LEN consecutive enabled samples, it raises a one-cycle `det` pulse. It also counts qualified events in a saturating counter for status readback.

## Interface
Parameters:
- RUN_LEN, default 4 — consecutive high samples required for an event; legal range 1..255.
- CNT_W, default 8 — width of the event counter.

Ports:
- clk  input  1  — single clock; all state updates on its rising edge.
- rst  input  1  — asynchronous, active-high reset.
- en  input  1  — sample enable; `o_in` is examined only on edges where en=1.
- o_in  input  1  — exactly-two-high indication from the upstream detector.
- clr  input  1  — synchronous clear of FSM, counters and sticky flag.
- det  output  1  — one-cycle pulse marking a qualified event.
- run_cnt  output  8  — current consecutive-high sample count, saturating at RUN_LEN.
- evt_cnt  output  CNT_W  — number of qualified events, saturating.
- sat  output  1  — sticky flag, set when evt_cnt reaches all-ones.

## Operation
- Reset values (asynchronous, immediate): state=IDLE, det=0, run_cnt=0, evt_cnt=0, sat=0.
- FSM states and transitions:
  - IDLE: en&o_in → COUNT with run_cnt=1. If RUN_LEN=1, go straight to LATCH and fire det instead.
  - COUNT: en&o_in → run_cnt+1. When the new value equals RUN_LEN → LATCH and fire det. en&~o_in → IDLE with run_cnt=0.
  - LATCH: en&o_in → stay; run_cnt holds RUN_LEN; no further det. en&~o_in → IDLE with run_cnt=0.
- en=0 freezes state, run_cnt, evt_cnt and sat. det is 0 on any cycle following an en=0 edge.
- Firing det:
  - evt_cnt increments on the same edge.
  - At all-ones, evt_cnt holds (no wrap), and sat is set on the edge where evt_cnt becomes all-ones.
  - det still pulses when evt_cnt is saturated.
- clr takes priority over en and o_in. On a clr edge: state=IDLE, run_cnt=0, evt_cnt=0, sat=0, det=0, and that edge's sample is discarded.
- Re-triggering requires at least one enabled low sample: a continuous high run yields exactly one event.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- det goes high the cycle after the edge that samples the RUN_LEN-th consecutive high. It lasts exactly one cycle.
- evt_cnt and sat update on the same edge as det rises.
- Disabled cycles (en=0) within a run do not break it. Consecutiveness counts enabled samples only.
- Reset asserted mid-run forces all outputs to their reset values immediately. After deassertion, counting restarts from IDLE on the first enabled edge.
- Simultaneous clr and a qualifying sample: clr wins, no det, no increment.

## Structure
- Shared package holds:
  - state encoding constants IDLE=2'd0, COUNT=2'd1, LATCH=2'd2; the code 2'd3 is illegal and recovers to IDLE;
  - the run_cnt width constant (8).
- One natural sub-module, `sat_counter` (width-parameterised, with inc and clr inputs, outputs count and at_max). It is used for evt_cnt.
- The FSM and run_cnt live in the top module.

## Test plan
- Reset, then RUN_LEN=4 and o_in=1 for 6 enabled cycles → one det pulse at the cycle after the 4th sample; run_cnt sequence 1,2,3,4,4,4; evt_cnt=1.
- Pattern 1,1,1,0,1,1,1,1 (en=1) → no det on the first run, run_cnt returns to 0, det after the 8th sample, evt_cnt=1.
- o_in=1 held, with en toggling 1,0,1,0,1,0,1 → det after the 4th enabled sample; run_cnt frozen on en=0 cycles.
- CNT_W=2, 5 separate qualified runs → evt_cnt sequence 1,2,3,3,3; sat=1 from the 3rd event on; det pulses 5 times; clr → evt_cnt=0, sat=0.
- clr asserted on the edge of the 4th high sample → det=0, evt_cnt=0, state IDLE; the next 4 highs produce det.
- rst pulsed asynchronously mid-COUNT (run_cnt=2) → all outputs 0 without waiting for a clock edge; RUN_LEN=1 variant: each isolated high sample produces det.
